// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and LSB result streams onto one common data bus.
// Each source owns a small FIFO; an idle source's live input bypasses its
// FIFO. Contested cycles alternate between sources, and each source keeps
// its results in arrival order.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rdy                       global enable (low freezes all state)
//   rollback                  flush all queued results and the bus
//   alu_result*/lsb_result*   per-source result valid, ROB tag and value
//   alu_stall, lsb_stall      combinational almost-full back-pressure
//   cdb_valid/rob_pos/val/src registered broadcast (src: 0 = ALU, 1 = LSB)
//   ovf_err                   sticky overflow flag, cleared only by reset

// Per-source result queue. The caller must only push when there is room
// (not full, or popping in the same cycle).
module cdb_src_q #(
  parameter int unsigned ENT_W  = 36,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENT_W-1:0]         din,
  output logic [ENT_W-1:0]         head,
  output logic [$clog2(QDEPTH):0]  count,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENT_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  assign head = mem[head_ptr];
  assign full = (count == CNT_W'(QDEPTH));

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (en) begin
      if (flush) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (push) tail_ptr <= tail_ptr + PTR_W'(1);
        if (pop)  head_ptr <= head_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  // Storage has no reset; entries are only read when count says they are live.
  always_ff @(posedge clk) begin
    if (en && !flush && push) mem[tail_ptr] <= din;
  end

endmodule

module cdb_arbiter #(
  parameter int unsigned ROB_POS_W = 4,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]          lsb_result_val,
  output logic                 alu_stall,
  output logic                 lsb_stall,
  output logic                 cdb_valid,
  output logic [ROB_POS_W-1:0] cdb_rob_pos,
  output logic [31:0]          cdb_val,
  output logic                 cdb_src,
  output logic                 ovf_err
);

  localparam int unsigned ENT_W = ROB_POS_W + 32;
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [ROB_POS_W-1:0] rob_pos;
    logic [31:0]          val;
  } cdb_ent_t;

  cdb_ent_t         alu_in, lsb_in;
  cdb_ent_t         alu_head, lsb_head;
  cdb_ent_t         alu_cand_d, lsb_cand_d, grant_d;
  logic [CNT_W-1:0] alu_cnt, lsb_cnt;
  logic             alu_full, lsb_full;
  logic             alu_has_q, lsb_has_q;
  logic             alu_cand, lsb_cand;
  logic             any_cand, contest, grant_lsb;
  logic             alu_pop, lsb_pop;
  logic             alu_push, lsb_push;
  logic             alu_push_ok, lsb_push_ok;
  logic             drop;
  // Source of the last contested grant; 1 means the ALU wins the next contest.
  logic             rr_last;

  assign alu_in = '{rob_pos: alu_result_rob_pos, val: alu_result_val};
  assign lsb_in = '{rob_pos: lsb_result_rob_pos, val: lsb_result_val};

  // Candidate selection, grant and queue control for this cycle.
  always_comb begin
    alu_has_q   = (alu_cnt != '0);
    lsb_has_q   = (lsb_cnt != '0);
    alu_cand    = alu_has_q || alu_result;
    lsb_cand    = lsb_has_q || lsb_result;
    alu_cand_d  = alu_has_q ? alu_head : alu_in;
    lsb_cand_d  = lsb_has_q ? lsb_head : lsb_in;
    any_cand    = alu_cand || lsb_cand;
    contest     = alu_cand && lsb_cand;
    grant_lsb   = contest ? !rr_last : lsb_cand;
    grant_d     = grant_lsb ? lsb_cand_d : alu_cand_d;

    alu_pop     = any_cand && !grant_lsb && alu_has_q;
    lsb_pop     = any_cand &&  grant_lsb && lsb_has_q;
    // A live input is queued unless it is the one going straight to the bus.
    alu_push    = alu_result && !(any_cand && !grant_lsb && !alu_has_q);
    lsb_push    = lsb_result && !(any_cand &&  grant_lsb && !lsb_has_q);
    alu_push_ok = alu_push && (!alu_full || alu_pop);
    lsb_push_ok = lsb_push && (!lsb_full || lsb_pop);
    drop        = (alu_push && !alu_push_ok) || (lsb_push && !lsb_push_ok);
  end

  cdb_src_q #(.ENT_W(ENT_W), .QDEPTH(QDEPTH)) u_alu_q (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (rollback),
    .push  (alu_push_ok),
    .pop   (alu_pop),
    .din   (alu_in),
    .head  (alu_head),
    .count (alu_cnt),
    .full  (alu_full)
  );

  cdb_src_q #(.ENT_W(ENT_W), .QDEPTH(QDEPTH)) u_lsb_q (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (rollback),
    .push  (lsb_push_ok),
    .pop   (lsb_pop),
    .din   (lsb_in),
    .head  (lsb_head),
    .count (lsb_cnt),
    .full  (lsb_full)
  );

  assign alu_stall = (alu_cnt >= CNT_W'(QDEPTH - 1));
  assign lsb_stall = (lsb_cnt >= CNT_W'(QDEPTH - 1));

  // Broadcast registers, round-robin state and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid   <= 1'b0;
      cdb_rob_pos <= '0;
      cdb_val     <= '0;
      cdb_src     <= 1'b0;
      rr_last     <= 1'b1;
      ovf_err     <= 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        cdb_valid <= 1'b0;
        rr_last   <= 1'b1;
      end else begin
        cdb_valid <= any_cand;
        if (any_cand) begin
          cdb_rob_pos <= grant_d.rob_pos;
          cdb_val     <= grant_d.val;
          cdb_src     <= grant_lsb;
        end
        if (contest) rr_last <= grant_lsb;
        if (drop)    ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, bypass, contest, fairness,
// overflow, rollback, freeze and mid-stream reset.
module tb_cdb_arbiter;

  localparam int unsigned PW = 4;
  localparam int unsigned QD = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, rollback;
  logic          alu_result, lsb_result;
  logic [PW-1:0] alu_pos, lsb_pos;
  logic [31:0]   alu_val, lsb_val;
  logic          alu_stall, lsb_stall, cdb_valid, cdb_src, ovf_err;
  logic [PW-1:0] cdb_rob_pos;
  logic [31:0]   cdb_val;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] log_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_POS_W(PW), .QDEPTH(QD)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .rollback           (rollback),
    .alu_result         (alu_result),
    .alu_result_rob_pos (alu_pos),
    .alu_result_val     (alu_val),
    .lsb_result         (lsb_result),
    .lsb_result_rob_pos (lsb_pos),
    .lsb_result_val     (lsb_val),
    .alu_stall          (alu_stall),
    .lsb_stall          (lsb_stall),
    .cdb_valid          (cdb_valid),
    .cdb_rob_pos        (cdb_rob_pos),
    .cdb_val            (cdb_val),
    .cdb_src            (cdb_src),
    .ovf_err            (ovf_err)
  );

  function automatic logic [31:0] val_of(input logic src, input logic [PW-1:0] pos);
    return 32'hC0DE_0000 | {27'd0, src, pos};
  endfunction

  function automatic logic [63:0] ent(input logic src, input logic [PW-1:0] pos);
    return {27'd0, src, pos, val_of(src, pos)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; logs every broadcast made while enabled.
  task automatic cyc(input logic av, input logic [PW-1:0] ap,
                     input logic lv, input logic [PW-1:0] lp);
    logic r;
    alu_result = av; alu_pos = ap; alu_val = val_of(1'b0, ap);
    lsb_result = lv; lsb_pos = lp; lsb_val = val_of(1'b1, lp);
    r = rdy;
    @(posedge clk); #1;
    if (r && cdb_valid) log_q.push_back({27'd0, cdb_src, cdb_rob_pos, cdb_val});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    alu_result = 1'b0; lsb_result = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    log_q.delete();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) check($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    alu_result = 1'b0; alu_pos = '0; alu_val = '0;
    lsb_result = 1'b0; lsb_pos = '0; lsb_val = '0;
    #2;
    check("reset_outputs", {27'd0, cdb_valid, cdb_src, ovf_err, alu_stall, lsb_stall, cdb_rob_pos, cdb_val},
          64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle bypass, then value hold while invalid.
    alu_result = 1'b1; alu_pos = 4'd3; alu_val = 32'h11;
    @(posedge clk); #1;
    alu_result = 1'b0;
    check("bypass", {cdb_valid, cdb_src, cdb_rob_pos, cdb_val}, {1'b1, 1'b0, 4'd3, 32'h11});
    check("bypass_stalls", {alu_stall, lsb_stall}, 2'b00);
    idle(1);
    check("bypass_gone", cdb_valid, 1'b0);
    check("hold_pos_val", {cdb_rob_pos, cdb_val}, {4'd3, 32'h11});
    log_q.delete();

    // Simultaneous contest right after reset: ALU first.
    do_reset();
    cyc(1'b1, 4'd1, 1'b1, 4'd2);
    check("contest_c1", {cdb_valid, cdb_src, cdb_rob_pos}, {1'b1, 1'b0, 4'd1});
    idle(1);
    check("contest_c2", {cdb_valid, cdb_src, cdb_rob_pos}, {1'b1, 1'b1, 4'd2});
    idle(1);
    check("contest_c3", cdb_valid, 1'b0);
    log_q.delete();

    // Fairness: both stream six cycles, then drain.
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1'b1, PW'(k), 1'b1, PW'(8 + k));
    idle(8);
    for (int i = 0; i < 12; i++)
      exp_q.push_back(ent(1'(i % 2), (i % 2 == 1) ? PW'(8 + i / 2) : PW'(i / 2)));
    check_log("fair");

    // ALU back-pressure and overflow while the LSB keeps winning half the grants.
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k == 6) check("alu_stall_c6", alu_stall, 1'b0);
      if (k == 7) check("alu_stall_c7", alu_stall, 1'b1);
      if (k == 8) check("lsb_stall_c8", lsb_stall, 1'b0);
      cyc(1'b1, PW'(k), (k == 1) || (k >= 2 && k % 2 == 0), PW'(k));
      if (k == 9)  check("ovf_c9", ovf_err, 1'b0);
      if (k == 10) check("ovf_c10", ovf_err, 1'b1);
    end
    idle(6);
    check("ovf_sticky", ovf_err, 1'b1);
    exp_q = '{ent(0, 0), ent(0, 1), ent(1, 1), ent(0, 2), ent(1, 2), ent(0, 3),
              ent(1, 4), ent(0, 4), ent(1, 6), ent(0, 5), ent(1, 8), ent(0, 6),
              ent(1, 10), ent(0, 7), ent(0, 8), ent(0, 9)};
    check_log("ovf");

    // Rollback with two entries queued per source; ovf_err survives it.
    rollback = 1'b1; idle(1); rollback = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b1, PW'(1 + k), 1'b1, PW'(9 + k));
    exp_q = '{ent(0, 1), ent(1, 9), ent(0, 2), ent(1, 10)};
    check_log("pre_rb");
    rollback = 1'b1;
    cyc(1'b1, 4'd7, 1'b1, 4'd15);
    rollback = 1'b0;
    check("rb_state", {cdb_valid, alu_stall, lsb_stall, ovf_err}, 4'b0001);
    idle(3);
    cyc(1'b1, 4'd5, 1'b1, 4'd6);
    idle(3);
    exp_q = '{ent(0, 5), ent(1, 6)};
    check_log("post_rb");

    // Freeze with toggling inputs, then resume from the pre-freeze head.
    do_reset();
    cyc(1'b1, 4'd1, 1'b1, 4'd9);
    cyc(1'b1, 4'd2, 1'b1, 4'd10);
    log_q.delete();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rollback = 1'(k % 2);
      cyc(1'(k % 2), PW'(12 + k), 1'((k + 1) % 2), PW'(4 + k));
      check($sformatf("freeze_%0d", k),
            {26'd0, alu_stall, lsb_stall, cdb_valid, cdb_src, cdb_rob_pos, cdb_val},
            {26'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, val_of(1'b1, 4'd9)});
    end
    rollback = 1'b0;
    rdy = 1'b1;
    idle(1);

    // Asynchronous reset mid-stream discards the queued LSB entry.
    rst = 1'b0;
    #1;
    check("async_rst", {cdb_valid, cdb_src, ovf_err, cdb_rob_pos, cdb_val}, 39'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(3);
    exp_q = '{ent(0, 2)};
    check_log("freeze_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_POS_W, default 4, width of ROB position tags.
REQ-002 Parameter QDEPTH, default 4, entries per source queue; power of two, at least 2.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 rdy  input  1  global enable; when low, all state is frozen.
REQ-006 rollback  input  1  misprediction flush from the ROB.
REQ-007 alu_result  input  1  ALU result valid this cycle.
REQ-008 alu_result_rob_pos  input  ROB_POS_W  ALU result tag.
REQ-009 alu_result_val  input  32  ALU result value.
REQ-010 lsb_result  input  1  LSB result valid this cycle.
REQ-011 lsb_result_rob_pos  input  ROB_POS_W  LSB result tag.
REQ-012 lsb_result_val  input  32  LSB result value.
REQ-013 alu_stall  output  1  ALU queue almost full; the RS must not dispatch.
REQ-014 lsb_stall  output  1  LSB queue almost full; the LSB must not start a new access.
REQ-015 cdb_valid  output  1  broadcast valid (registered).
REQ-016 cdb_rob_pos  output  ROB_POS_W  broadcast tag (registered).
REQ-017 cdb_val  output  32  broadcast value (registered).
REQ-018 cdb_src  output  1  broadcast source: 0 = ALU, 1 = LSB (registered).
REQ-019 ovf_err  output  1  sticky overflow flag (registered).

Function
REQ-020 Each source SHALL have a QDEPTH-entry FIFO of {rob_pos, val}, with head and tail pointers that wrap modulo QDEPTH and a count ranging 0..QDEPTH.
REQ-021 Each source's candidate SHALL be its FIFO head if the count is greater than 0; otherwise it SHALL be its current input if that input is valid; otherwise the source has no candidate.
REQ-022 Exactly one candidate per cycle SHALL be granted and loaded into the cdb_* registers; with no candidates, cdb_valid SHALL be 0 on the next cycle.
REQ-023 When both sources have candidates, the grant SHALL go to the source that did not receive the last contested grant; rr_last SHALL update only on contested grants.
REQ-024 A valid input that is not itself the granted candidate SHALL be pushed into its FIFO in the same cycle.
REQ-025 A granted FIFO head SHALL be popped; a simultaneous push and pop SHALL leave the count unchanged.
REQ-026 Latency: an input result arriving at an idle arbiter SHALL appear on the cdb_* outputs in cycle N+1 (bypass path).
REQ-027 Per source, broadcast order SHALL equal arrival order.
REQ-028 x_stall SHALL be combinational and equal to (count_x >= QDEPTH-1).
REQ-029 A result arriving in the cycle its stall rises SHALL still be accepted.
REQ-030 A push into a full FIFO that is not popped in the same cycle SHALL be dropped, leave the FIFO unchanged, and set ovf_err=1 until reset.
REQ-031 Rollback high with rdy high SHALL, on that edge:
- empty both FIFOs (count, head and tail = 0);
- clear cdb_valid;
- set rr_last=1, so the ALU wins the next contest;
- ignore the inputs of that cycle.
ovf_err SHALL be unaffected by rollback.
REQ-032 rdy low SHALL hold every register; inputs presented while rdy is low SHALL be ignored.
REQ-033 cdb_val and cdb_rob_pos SHALL hold their previous values when cdb_valid=0.

Reset
REQ-034 rst low SHALL immediately force the following, regardless of clk and rdy:
- all FIFO counts and pointers = 0;
- cdb_valid=0, cdb_rob_pos=0, cdb_val=0, cdb_src=0;
- rr_last=1;
- ovf_err=0.
REQ-035 The block SHALL resume operation on the first rising edge after rst returns high; a reset in mid-stream SHALL discard all queued results.

Verification
REQ-036 Idle bypass: alu_result=1, pos=3, val=0x11 in cycle 0 -> cycle 1: cdb_valid=1, pos=3, val=0x11, src=0; FIFOs empty.
REQ-037 Contest: ALU (pos 1) and LSB (pos 2) valid in the same cycle after reset -> ALU broadcast on cycle 1, LSB broadcast on cycle 2, then cdb_valid=0.
REQ-038 Fairness: both sources stream every cycle for 6 cycles -> the cdb_src sequence alternates 0,1,0,1,..., and each source keeps its tags in arrival order.
REQ-039 Backpressure/overflow (QDEPTH=4): LSB continuously granted, ALU pushes every cycle -> alu_stall rises at count 3; one further push is accepted; the next push while full sets ovf_err=1 and drops that entry.
REQ-040 Rollback: with 2 entries queued per source, pulse rollback -> next cycle cdb_valid=0, both stalls low, and no old tag is ever broadcast afterwards.
REQ-041 Freeze: rdy low for 3 cycles with inputs toggling -> outputs and counts are unchanged, and the next broadcast after rdy returns high is the pre-freeze queue head.
